mem_bus_test_monitor: RTL

MEM_BUS_TEST_MONITOR -- requirements
Module: mem_bus_test_monitor

---
 rtl/mist1032sa_test_pkg.sv | 27 ++
 rtl/mem_bus_test_log_fifo.sv | 56 +++++
 rtl/mem_bus_test_monitor.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mist1032sa_test_pkg.sv
// Shared constants and types for the memory-bus test mailbox monitor.
// Mailbox offsets, bus order code, FSM state type and timeout code.
package mist1032sa_test_pkg;

  localparam logic [31:0] OFS_FLAG   = 32'h00;
  localparam logic [31:0] OFS_FINISH = 32'h04;
  localparam logic [31:0] OFS_LOG    = 32'h08;
  localparam logic [31:0] OFS_TYPE   = 32'h0C;
  localparam logic [31:0] OFS_INDEX  = 32'h10;
  localparam logic [31:0] OFS_RESULT = 32'h14;
  localparam logic [31:0] OFS_EXPECT = 32'h18;
  localparam logic [31:0] WIN_SIZE   = 32'h20;

  localparam logic [1:0] ORDER_WORD = 2'h2;

  localparam logic [31:0] TYPE_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_RUN,
    ST_DONE
  } monState_t;

  function automatic logic [31:0] byteSwap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/mem_bus_test_log_fifo.sv
// Log FIFO for the test monitor: no bypass, sticky overflow on dropped push.
// Extra pointer bit distinguishes full from empty.
module mem_bus_test_log_fifo #(
  parameter int P_DEPTH = 8
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        push,
  input  logic [31:0] pushData,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic        overflow
);

  localparam int AW = $clog2(P_DEPTH);

  logic [31:0] mem [P_DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        doWr;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign pop   = !empty && ready;
  // A pop in the same cycle frees the slot a full push needs.
  assign doWr  = push && (!full || pop);

  assign valid = !empty;
  assign data  = empty ? 32'h0 : mem[rdPtr[AW-1:0]];

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doWr)
        wrPtr <= wrPtr + 1'b1;
      if (pop)
        rdPtr <= rdPtr + 1'b1;
      if (push && !doWr)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (doWr && !iRESET_SYNC)
      mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/mem_bus_test_monitor.sv
// Passive memory-bus mailbox monitor: verdict, error record, watchdog.
// Log path built only when MIST1032SA_TEST_MONITOR_LOG_EN is defined.
module mem_bus_test_monitor
  import mist1032sa_test_pkg::*;
#(
  parameter logic [31:0] P_BASE_ADDR = 32'h0002_0000,
  parameter int          P_LOG_DEPTH = 8,
  parameter logic [31:0] P_TIMEOUT   = 32'd750000
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iMEMORY_REQ,
  input  logic        iMEMORY_LOCK,
  input  logic [1:0]  iMEMORY_ORDER,
  input  logic        iMEMORY_RW,
  input  logic [31:0] iMEMORY_ADDR,
  input  logic [31:0] iMEMORY_DATA,
  output logic        oDONE,
  output logic        oPASS,
  output logic [31:0] oERR_TYPE,
  output logic [31:0] oERR_INDEX,
  output logic [31:0] oERR_RESULT,
  output logic [31:0] oERR_EXPECT,
  output logic        oLOG_VALID,
  output logic [31:0] oLOG_DATA,
  output logic        oLOG_OVERFLOW,
  input  logic        iLOG_READY
);

`ifdef MIST1032SA_TEST_MONITOR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  monState_t   state;
  logic        flag;
  logic        pass;
  logic [31:0] errType;
  logic [31:0] errIndex;
  logic [31:0] errResult;
  logic [31:0] errExpect;
  logic [31:0] wdog;

  logic        accept;
  logic [31:0] offset;
  logic        inWindow;
  logic        hit;
  logic [31:0] swapped;
  logic        isFlag;
  logic        isFinish;
  logic        isLog;
  logic        isType;
  logic        isIndex;
  logic        isResult;
  logic        isExpect;
  logic        expire;

  assign accept = iMEMORY_REQ && !iMEMORY_LOCK &&
                  (iMEMORY_ORDER == ORDER_WORD) && iMEMORY_RW;

  // Addresses below the base wrap to large offsets and miss the window.
  assign offset   = iMEMORY_ADDR - P_BASE_ADDR;
  assign inWindow = (offset < WIN_SIZE) && (offset[1:0] == 2'b00);

  assign hit = accept && inWindow && (state == ST_RUN) &&
               !iRESET_SYNC && !((offset == OFS_LOG) && !LOG_EN);

  assign swapped  = byteSwap(iMEMORY_DATA);
  assign isFlag   = hit && (offset == OFS_FLAG);
  assign isFinish = hit && (offset == OFS_FINISH);
  assign isLog    = hit && (offset == OFS_LOG);
  assign isType   = hit && (offset == OFS_TYPE);
  assign isIndex  = hit && (offset == OFS_INDEX);
  assign isResult = hit && (offset == OFS_RESULT);
  assign isExpect = hit && (offset == OFS_EXPECT);

  assign expire = (P_TIMEOUT != 32'd0) && !hit &&
                  (wdog == P_TIMEOUT - 32'd1);

  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state     <= ST_RUN;
      flag      <= 1'b0;
      pass      <= 1'b0;
      errType   <= 32'h0;
      errIndex  <= 32'h0;
      errResult <= 32'h0;
      errExpect <= 32'h0;
      wdog      <= 32'h0;
    end else if (state == ST_RUN) begin
      wdog <= hit ? 32'h0 : wdog + 32'd1;
      unique case (1'b1)
        isFlag:   flag      <= swapped[0];
        isType:   errType   <= swapped;
        isIndex:  errIndex  <= swapped;
        isResult: errResult <= swapped;
        isExpect: errExpect <= swapped;
        default: ;
      endcase
      if (isFinish) begin
        state <= ST_DONE;
        pass  <= flag;
      end else if (expire) begin
        state   <= ST_DONE;
        pass    <= 1'b0;
        errType <= TYPE_TIMEOUT;
      end
    end
  end

  assign oDONE       = (state == ST_DONE);
  assign oPASS       = pass;
  assign oERR_TYPE   = errType;
  assign oERR_INDEX  = errIndex;
  assign oERR_RESULT = errResult;
  assign oERR_EXPECT = errExpect;

`ifdef MIST1032SA_TEST_MONITOR_LOG_EN
  mem_bus_test_log_fifo #(
    .P_DEPTH(P_LOG_DEPTH)
  ) uLogFifo (
    .iCLOCK     (iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .push       (isLog),
    .pushData   (swapped),
    .ready      (iLOG_READY),
    .valid      (oLOG_VALID),
    .data       (oLOG_DATA),
    .overflow   (oLOG_OVERFLOW)
  );
`else
  assign oLOG_VALID    = 1'b0;
  assign oLOG_DATA     = 32'h0;
  assign oLOG_OVERFLOW = 1'b0;
`endif

endmodule
